// File: rtl/mult_unit_pkg.sv
// Shared execute-stage definitions: multiplier FSM encoding, default
// datapath width and the ALU decoder encodings used around the multiplier.
package mult_unit_pkg;

  // Default operand width of the integer datapath.
  localparam int MULT_WIDTH = 32;

  // Multiplier FSM state encoding (kept as plain constants for older tools).
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_FIX  = 2'b10;

  // Main decoder -> ALU decoder operation class.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // ALU decoder -> ALU control encoding.
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alucontrol_t;

endpackage

// File: rtl/mult_datapath.sv
// Shift-add datapath of the iterative multiplier. Works on operand
// magnitudes and applies the sign once, on the accumulated product.
module mult_datapath
  import mult_unit_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               signd,
  input  logic [WIDTH-1:0]   srca,
  input  logic [WIDTH-1:0]   srcb,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] mcand_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic               neg_reg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  // Magnitudes; -2^(WIDTH-1) negates to itself, which is the right unsigned value.
  assign mag_a = (signd & srca[WIDTH-1]) ? -srca : srca;
  assign mag_b = (signd & srcb[WIDTH-1]) ? -srcb : srcb;

  // Load operands on accept, then one shift-add per step: the multiplicand
  // walks left and the multiplier walks right so bit 0 is always the current bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      neg_reg    <= 1'b0;
    end else if (load) begin
      mcand_reg  <= {{WIDTH{1'b0}}, mag_a};
      mplier_reg <= mag_b;
      acc_reg    <= '0;
      neg_reg    <= signd & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
    end else if (step) begin
      if (mplier_reg[0]) begin
        acc_reg <= acc_reg + mcand_reg;
      end
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
    end
  end

  // Signed result is the two's-complement negation of the magnitude product.
  assign product = neg_reg ? -acc_reg : acc_reg;

endmodule

// File: rtl/mult_unit.sv
// Background iterative multiplier owning the HI/LO registers. Sequences the
// datapath, handles mthi/mtlo and flush, and stalls the pipeline on hazards.
module mult_unit
  import mult_unit_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             multseld,
  input  logic             signd,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  input  logic             hilo_rd,
  input  logic             hiwe,
  input  logic             lowe,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  logic [1:0]         state_reg;
  logic [CNTW-1:0]    cnt_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               done_reg;
  logic               accept;
  logic               step;
  logic [2*WIDTH-1:0] product;

  assign accept = (state_reg == S_IDLE) & start & multseld & ~flush;
  assign step   = (state_reg == S_RUN) & ~flush;

  mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .step    (step),
    .signd   (signd),
    .srca    (srca),
    .srcb    (srcb),
    .product (product)
  );

  // FSM, iteration counter and HI/LO: mthi/mtlo only land while idle, the
  // product lands on the FIX edge unless a flush kills it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (hiwe) hi_reg <= wd;
          if (lowe) lo_reg <= wd;
          if (accept) begin
            state_reg <= S_RUN;
            cnt_reg   <= '0;
          end
        end
        S_RUN: begin
          if (flush) begin
            state_reg <= S_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == CNTW'(WIDTH - 1)) begin
              state_reg <= S_FIX;
            end
          end
        end
        S_FIX: begin
          state_reg <= S_IDLE;
          if (!flush) begin
            {hi_reg, lo_reg} <= product;
            done_reg         <= 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign hi    = hi_reg;
  assign lo    = lo_reg;
  assign done  = done_reg;
  assign busy  = (state_reg != S_IDLE);
  // Combinational so the offending instruction is held in the same cycle.
  assign stall = busy & ((start & multseld) | hilo_rd | hiwe | lowe);

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: a cycle-level behavioural model built
// from plain 64-bit arithmetic, directed scenarios with literal results and
// a randomized phase.
module tb_mult_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, multseld = 1'b0, signd = 1'b0, flush = 1'b0;
  logic        hilo_rd = 1'b0, hiwe = 1'b0, lowe = 1'b0;
  logic [31:0] srca = '0, srcb = '0, wd = '0;
  logic [31:0] hi, lo;
  logic        busy, done, stall;

  int total = 0;
  int bad = 0;

  // behavioural model state
  bit          m_busy, m_done, m_acc;
  int          m_left;
  logic [63:0] m_prod;
  logic [31:0] m_hi, m_lo;
  logic        smp_stall;

  mult_unit dut (
    .clk(clk), .reset(reset), .start(start), .multseld(multseld), .signd(signd),
    .srca(srca), .srcb(srcb), .flush(flush), .hilo_rd(hilo_rd), .hiwe(hiwe),
    .lowe(lowe), .wd(wd), .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_prod(input bit sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (sg) begin
      sa = $signed(a);
      sb = $signed(b);
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_acc = 0; m_left = 0; m_hi = '0; m_lo = '0; m_prod = '0;
  endtask

  // One clock edge of the architectural behaviour: 33 edges after accept the
  // product appears, unless a flush intervenes.
  task automatic model_step();
    m_acc  = 0;
    m_done = 0;
    if (reset) begin
      model_reset();
    end else if (m_busy) begin
      if (flush) begin
        m_busy = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          {m_hi, m_lo} = m_prod;
          m_done = 1;
          m_busy = 0;
        end
      end
    end else begin
      if (hiwe) m_hi = wd;
      if (lowe) m_lo = wd;
      if (start && multseld && !flush) begin
        m_acc  = 1;
        m_busy = 1;
        m_left = 33;
        m_prod = ref_prod(signd, srca, srcb);
      end
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cyc();
    #1;
    smp_stall = stall;
    chk("stall", stall, m_busy && ((start && multseld) || hilo_rd || hiwe || lowe));
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
  endtask

  task automatic idle_inputs();
    start = 0; multseld = 0; flush = 0; hilo_rd = 0; hiwe = 0; lowe = 0;
  endtask

  // Issue one multiply from idle and wait for done; reports latency and busy cycles.
  task automatic mult_op(input bit sg, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt);
    start = 1; multseld = 1; signd = sg; srca = a; srcb = b;
    cyc();
    idle_inputs();
    srca = $urandom; srcb = $urandom; signd = $urandom_range(0, 1);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (busy) bcnt++;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat, bcnt, scnt;
    model_reset();
    #1;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    @(negedge clk);
    reset = 0;
    cyc();

    // unsigned max*max
    mult_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
    chk("u_hi", hi, 32'hFFFFFFFE);
    chk("u_lo", lo, 32'h00000001);
    chk("u_latency", lat, 33);
    chk("u_busy_cycles", bcnt, 33);
    cyc();
    chk("u_done_once", done, 1'b0);

    // signed
    mult_op(1, 32'hFFFFFFFF, 32'h00000002, lat, bcnt);
    chk("s1_hi", hi, 32'hFFFFFFFF);
    chk("s1_lo", lo, 32'hFFFFFFFE);
    mult_op(1, 32'h80000000, 32'h80000000, lat, bcnt);
    chk("s2_hi", hi, 32'h40000000);
    chk("s2_lo", lo, 32'h00000000);
    cyc();

    // hazard: reads and a second multiply while busy
    start = 1; multseld = 1; signd = 0; srca = 32'd1000; srcb = 32'd1000;
    cyc();
    idle_inputs();
    repeat (4) cyc();
    hilo_rd = 1; start = 1; multseld = 1; signd = 1; srca = 32'hFFFFFFF9; srcb = 32'd6;
    scnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (m_acc) break;
      if (smp_stall) scnt++;
    end
    chk("hz_stall_cycles", scnt, 29);
    chk("hz_first_lo", lo, 32'd1000000);
    idle_inputs();
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("hz_latency", lat, 33);
    chk("hz_hi", hi, 32'hFFFFFFFF);
    chk("hz_lo", lo, 32'hFFFFFFD6);

    // flush with preloaded HI/LO
    hiwe = 1; wd = 32'h1234;
    cyc();
    hiwe = 0; lowe = 1; wd = 32'h5678;
    cyc();
    idle_inputs();
    start = 1; multseld = 1; signd = 0; srca = 32'd99; srcb = 32'd77;
    cyc();
    idle_inputs();
    repeat (9) cyc();
    flush = 1;
    cyc();
    flush = 0;
    chk("fl_hi", hi, 32'h1234);
    chk("fl_lo", lo, 32'h5678);
    chk("fl_busy", busy, 1'b0);
    scnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (done) scnt++;
    end
    chk("fl_no_done", scnt, 0);

    // reset mid-run
    start = 1; multseld = 1; signd = 0; srca = 32'h11111111; srcb = 32'd3;
    cyc();
    idle_inputs();
    repeat (19) cyc();
    reset = 1;
    #1;
    model_reset();
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    repeat (2) cyc();
    reset = 0;
    cyc();
    mult_op(0, 32'd7, 32'd6, lat, bcnt);
    chk("rst_7x6_lo", lo, 32'd42);
    chk("rst_7x6_hi", hi, 32'd0);

    // mtlo while busy is held off
    start = 1; multseld = 1; signd = 0; srca = 32'd3; srcb = 32'd5;
    cyc();
    idle_inputs();
    repeat (5) cyc();
    lowe = 1; wd = 32'hDEAD;
    cyc();
    chk("mtlo_stall", smp_stall, 1'b1);
    chk("mtlo_blocked", lo, 32'd42);
    lowe = 0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("mtlo_done_seen", lat != 0, 1'b1);
    chk("mtlo_lo", lo, 32'd15);
    chk("mtlo_hi", hi, 32'd0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      start    = ($urandom_range(0, 2) == 0);
      multseld = ($urandom_range(0, 3) != 0);
      signd    = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: srca = 32'h80000000;
        1: srca = 32'hFFFFFFFF;
        default: srca = $urandom;
      endcase
      srcb    = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom;
      flush   = ($urandom_range(0, 40) == 0);
      hilo_rd = ($urandom_range(0, 7) == 0);
      hiwe    = ($urandom_range(0, 9) == 0);
      lowe    = ($urandom_range(0, 9) == 0);
      wd      = $urandom;
      cyc();
    end
    idle_inputs();
    repeat (40) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
